ntsc_composite_gen: RTL

- Builds the NTSC baseband video envelope directly upstream of the AM modulator stage.
- Consumes an 8-bit luma pixel stream over AXI-Stream and inserts horizontal and vertical sync and blanking.
- Emits one unsigned 16-bit envelope sample per transfer at the RF sample clock, using negative-modulation levels.
- Timing is free-running: it stalls only on downstream backpressure, never on missing pixels.

---
 rtl/ntsc_pkg.sv | 29 ++
 rtl/ntsc_luma_scale.sv | 21 ++
 rtl/ntsc_composite_gen.sv | 212 +++++++++++++++++++++
 3 files changed

// File: rtl/ntsc_pkg.sv
// Shared types and defaults for the NTSC baseband envelope generator and
// the luma/chroma level stages that feed it.
package ntsc_pkg;

  typedef enum logic [1:0] {
    SEG_SYNC,
    SEG_BACK,
    SEG_ACTIVE,
    SEG_FRONT
  } seg_t;

  typedef enum logic [1:0] {
    LINE_BROAD,
    LINE_BLANK,
    LINE_VIDEO
  } line_t;

  // Negative modulation: higher envelope means less light.
  localparam int unsigned DEF_SYNC_LVL  = 65535;
  localparam int unsigned DEF_BLANK_LVL = 49152;
  localparam int unsigned DEF_BLACK_LVL = 46694;
  localparam int unsigned DEF_WHITE_LVL = 8192;

  localparam int unsigned LEVEL_W      = 16;
  localparam int unsigned PIX_W        = 8;
  localparam int unsigned SAMPLE_CNT_W = 16;
  localparam int unsigned LINE_CNT_W   = 10;

endpackage

// File: rtl/ntsc_luma_scale.sv
// Maps an 8-bit luma code onto the envelope range between black and white.
module ntsc_luma_scale
  import ntsc_pkg::*;
#(
  parameter int unsigned BLACK_LVL = DEF_BLACK_LVL,
  parameter int unsigned WHITE_LVL = DEF_WHITE_LVL
) (
  input  logic [PIX_W-1:0]   pix,
  output logic [LEVEL_W-1:0] level
);

  localparam logic [LEVEL_W-1:0] DELTA = LEVEL_W'(BLACK_LVL - WHITE_LVL);

  logic [LEVEL_W+PIX_W-1:0] product;

  always_comb begin
    product = (LEVEL_W + PIX_W)'(DELTA) * (LEVEL_W + PIX_W)'(pix);
    level   = LEVEL_W'(BLACK_LVL) - product[LEVEL_W+PIX_W-1:PIX_W];
  end

endmodule

// File: rtl/ntsc_composite_gen.sv
// Free-running NTSC envelope generator: sync/blanking timing plus AXI-Stream
// luma consumption, one registered 16-bit sample per output transfer.
module ntsc_composite_gen
  import ntsc_pkg::*;
#(
  parameter int unsigned C_S00_AXIS_TDATA_WIDTH = 8,
  parameter int unsigned C_M00_AXIS_TDATA_WIDTH = 32,
  parameter int unsigned H_SYNC            = 4700,
  parameter int unsigned H_BACK            = 4700,
  parameter int unsigned H_ACTIVE          = 52600,
  parameter int unsigned H_FRONT           = 1556,
  parameter int unsigned SAMPLES_PER_PIXEL = 100,
  parameter int unsigned V_TOTAL           = 525,
  parameter int unsigned V_SYNC            = 3,
  parameter int unsigned V_BLANK           = 20,
  parameter int unsigned SYNC_LVL          = DEF_SYNC_LVL,
  parameter int unsigned BLANK_LVL         = DEF_BLANK_LVL,
  parameter int unsigned BLACK_LVL         = DEF_BLACK_LVL,
  parameter int unsigned WHITE_LVL         = DEF_WHITE_LVL
) (
  input  logic                                s00_axis_aclk,
  input  logic                                s00_axis_aresetn,
  input  logic                                s00_axis_tvalid,
  input  logic [C_S00_AXIS_TDATA_WIDTH-1:0]   s00_axis_tdata,
  input  logic                                s00_axis_tlast,
  output logic                                s00_axis_tready,
  input  logic                                m00_axis_tready,
  output logic                                m00_axis_tvalid,
  output logic [C_M00_AXIS_TDATA_WIDTH-1:0]   m00_axis_tdata,
  output logic                                m00_axis_tlast,
  output logic [C_M00_AXIS_TDATA_WIDTH/8-1:0] m00_axis_tstrb,
  output logic [15:0]                         underflow_count
);

  localparam int unsigned H_TOTAL = H_SYNC + H_BACK + H_ACTIVE + H_FRONT;
  localparam int unsigned N_SLOTS = H_ACTIVE / SAMPLES_PER_PIXEL;
  localparam int unsigned SW      = SAMPLE_CNT_W;
  localparam int unsigned LW      = LINE_CNT_W;

  seg_t               seg_q, seg_d;
  line_t              kind;
  logic [SW-1:0]      seg_cnt_q, seg_cnt_d;
  logic [SW-1:0]      h_cnt_q, h_cnt_d;
  logic [SW-1:0]      pix_cnt_q, pix_cnt_d;
  logic [SW-1:0]      slot_cnt_q, slot_cnt_d;
  logic [LW-1:0]      line_q, line_d;
  logic               drain_q, drain_d;
  logic               done_q, done_d;
  logic               show_q, show_d;
  logic [PIX_W-1:0]   pix_q, pix_d;
  logic [15:0]        uf_q, uf_d;
  logic [LEVEL_W-1:0] level_q, level_d;
  logic               tlast_q, tlast_d;
  logic               valid_q;

  logic               advance;
  logic               seg_last;
  logic               in_active;
  logic               slot;
  logic               last_slot;
  logic               s_ready;
  logic               show_now;
  logic [PIX_W-1:0]   luma_pix;
  logic [LEVEL_W-1:0] luma_level;

  ntsc_luma_scale #(
    .BLACK_LVL (BLACK_LVL),
    .WHITE_LVL (WHITE_LVL)
  ) u_luma (
    .pix   (luma_pix),
    .level (luma_level)
  );

  always_comb begin
    advance = m00_axis_tready || !valid_q;

    if (line_q < LW'(V_SYNC))       kind = LINE_BROAD;
    else if (line_q < LW'(V_BLANK)) kind = LINE_BLANK;
    else                            kind = LINE_VIDEO;

    // Segment sequencing; the line counter steps on the last FRONT sample.
    seg_last = 1'b0;
    unique case (seg_q)
      SEG_SYNC:   seg_last = (seg_cnt_q == SW'(H_SYNC - 1));
      SEG_BACK:   seg_last = (seg_cnt_q == SW'(H_BACK - 1));
      SEG_ACTIVE: seg_last = (seg_cnt_q == SW'(H_ACTIVE - 1));
      SEG_FRONT:  seg_last = (seg_cnt_q == SW'(H_FRONT - 1));
    endcase

    seg_d     = seg_q;
    seg_cnt_d = seg_cnt_q + 1'b1;
    h_cnt_d   = h_cnt_q + 1'b1;
    line_d    = line_q;
    if (seg_last) begin
      seg_cnt_d = '0;
      unique case (seg_q)
        SEG_SYNC:   seg_d = SEG_BACK;
        SEG_BACK:   seg_d = SEG_ACTIVE;
        SEG_ACTIVE: seg_d = SEG_FRONT;
        SEG_FRONT:  seg_d = SEG_SYNC;
      endcase
      if (seg_q == SEG_FRONT) begin
        h_cnt_d = '0;
        line_d  = (line_q == LW'(V_TOTAL - 1)) ? '0 : line_q + 1'b1;
      end
    end

    in_active = (seg_q == SEG_ACTIVE) && (kind == LINE_VIDEO);
    slot      = in_active && (pix_cnt_q == '0);
    last_slot = slot && (slot_cnt_q == SW'(N_SLOTS - 1));

    pix_cnt_d  = '0;
    slot_cnt_d = '0;
    if (in_active) begin
      if (pix_cnt_q == SW'(SAMPLES_PER_PIXEL - 1)) begin
        pix_cnt_d  = '0;
        slot_cnt_d = slot_cnt_q + 1'b1;
      end else begin
        pix_cnt_d  = pix_cnt_q + 1'b1;
        slot_cnt_d = slot_cnt_q;
      end
    end

    // While draining, every non-ACTIVE sample (and each ACTIVE slot) discards.
    if (drain_q) s_ready = advance && ((seg_q != SEG_ACTIVE) || slot);
    else         s_ready = advance && slot && !done_q;

    drain_d = drain_q;
    done_d  = (seg_q == SEG_ACTIVE) ? done_q : 1'b0;
    show_d  = slot ? 1'b0 : show_q;
    pix_d   = pix_q;
    uf_d    = uf_q;
    if (drain_q) begin
      if (s_ready && s00_axis_tvalid && s00_axis_tlast) begin
        drain_d = 1'b0;
        if (seg_q == SEG_ACTIVE) done_d = 1'b1;
      end
    end else if (slot && !done_q) begin
      if (s00_axis_tvalid) begin
        pix_d  = s00_axis_tdata[PIX_W-1:0];
        show_d = 1'b1;
        if (s00_axis_tlast && !last_slot) done_d = 1'b1;
        if (!s00_axis_tlast && last_slot) drain_d = 1'b1;
      end else if (uf_q != '1) begin
        uf_d = uf_q + 1'b1;
      end
    end

    // The slot sample already shows the pixel being accepted.
    luma_pix = slot ? s00_axis_tdata[PIX_W-1:0] : pix_q;
    show_now = slot ? (!drain_q && !done_q && s00_axis_tvalid) : show_q;

    level_d = LEVEL_W'(BLANK_LVL);
    if (kind == LINE_BROAD) begin
      if (h_cnt_q < SW'(H_TOTAL - H_SYNC)) level_d = LEVEL_W'(SYNC_LVL);
    end else begin
      unique case (seg_q)
        SEG_SYNC:   level_d = LEVEL_W'(SYNC_LVL);
        SEG_ACTIVE: begin
          if (kind == LINE_VIDEO)
            level_d = show_now ? luma_level : LEVEL_W'(BLACK_LVL);
        end
        default:    level_d = LEVEL_W'(BLANK_LVL);
      endcase
    end
    tlast_d = (h_cnt_q == SW'(H_TOTAL - 1));
  end

  always_ff @(posedge s00_axis_aclk or negedge s00_axis_aresetn) begin
    if (!s00_axis_aresetn) begin
      seg_q      <= SEG_SYNC;
      seg_cnt_q  <= '0;
      h_cnt_q    <= '0;
      pix_cnt_q  <= '0;
      slot_cnt_q <= '0;
      line_q     <= '0;
      drain_q    <= 1'b0;
      done_q     <= 1'b0;
      show_q     <= 1'b0;
      pix_q      <= '0;
      uf_q       <= '0;
      level_q    <= '0;
      tlast_q    <= 1'b0;
      valid_q    <= 1'b0;
    end else begin
      valid_q <= 1'b1;
      if (advance) begin
        seg_q      <= seg_d;
        seg_cnt_q  <= seg_cnt_d;
        h_cnt_q    <= h_cnt_d;
        pix_cnt_q  <= pix_cnt_d;
        slot_cnt_q <= slot_cnt_d;
        line_q     <= line_d;
        drain_q    <= drain_d;
        done_q     <= done_d;
        show_q     <= show_d;
        pix_q      <= pix_d;
        uf_q       <= uf_d;
        level_q    <= level_d;
        tlast_q    <= tlast_d;
      end
    end
  end

  assign s00_axis_tready = s_ready;
  assign m00_axis_tvalid = valid_q;
  assign m00_axis_tdata  = C_M00_AXIS_TDATA_WIDTH'(level_q);
  assign m00_axis_tlast  = tlast_q;
  assign m00_axis_tstrb  = '1;
  assign underflow_count = uf_q;

endmodule
